// File: rtl/mem_array_arbiter.sv
// ============================================================================
// Module   : mem_array_arbiter
// Purpose  : Round-robin, non-preemptive owner arbiter for the shared memArray
//            tristate nets, with a fixed bus-turnaround gap between owners.
//            Optional grant timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_array_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 16
) (
  input  logic                       clk,
  input  logic                       resetH,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       gntValid,
  output logic [$clog2(NUM_REQ)-1:0] gntId,
  output logic                       busIdle,
  output logic                       timeout
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURN_CYCLES - 1);
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT      = 2'd1,
    TURNAROUND = 2'd2
  } arbState_e;

  arbState_e            r_state, w_nextState;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt;
  logic                 r_gntValid;
  logic [ID_W-1:0]      r_gntId, w_gntId;
  logic                 r_busIdle;
  logic [ID_W-1:0]      r_rrPtr, w_rrPtr;
  logic [TURN_W-1:0]    r_turnCnt, w_turnCnt;
  logic [ID_W-1:0]      w_winner;
  logic                 w_anyReq;
  logic                 w_found;
  logic                 w_doGrant;
  logic                 w_doRelease;
  int                   w_scanIdx;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  logic [HOLD_W-1:0]    r_holdCnt, w_holdCnt;
  logic                 r_timeout, w_timeout;
`else
  localparam int unusedMaxHold = MAX_HOLD;
`endif

  // First requester at or after rrPtr, wrapping modulo NUM_REQ.
  always_comb begin
    w_anyReq  = |req;
    w_winner  = r_rrPtr;
    w_found   = 1'b0;
    w_scanIdx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scanIdx = int'(r_rrPtr) + k;
      if (w_scanIdx >= NUM_REQ) w_scanIdx = w_scanIdx - NUM_REQ;
      if (!w_found && req[ID_W'(w_scanIdx)]) begin
        w_found  = 1'b1;
        w_winner = ID_W'(w_scanIdx);
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_gnt       = r_gnt;
    w_gntId     = r_gntId;
    w_rrPtr     = r_rrPtr;
    w_turnCnt   = r_turnCnt;
    w_doGrant   = 1'b0;
    w_doRelease = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    w_holdCnt   = r_holdCnt;
    w_timeout   = 1'b0;
`endif

    case (r_state)
      IDLE: begin
        if (w_anyReq) w_doGrant = 1'b1;
      end
      GRANT: begin
        if (!req[r_gntId]) begin
          w_doRelease = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
        end else if (r_holdCnt == HOLD_LAST) begin
          w_doRelease = 1'b1;
          w_timeout   = 1'b1;
        end else begin
          w_holdCnt = r_holdCnt + 1'b1;
`endif
        end
      end
      TURNAROUND: begin
        if (r_turnCnt != '0) begin
          w_turnCnt = r_turnCnt - 1'b1;
        end else if (w_anyReq) begin
          w_doGrant = 1'b1;
        end else begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase

    if (w_doGrant) begin
      w_nextState = GRANT;
      w_gnt       = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
      w_gntId     = w_winner;
`ifdef MEM_ARB_TIMEOUT_EN
      w_holdCnt   = '0;
`endif
    end

    // Pointer moves past the released owner so it loses to any other waiter.
    if (w_doRelease) begin
      w_nextState = TURNAROUND;
      w_gnt       = '0;
      w_turnCnt   = TURN_LOAD;
      w_rrPtr     = (r_gntId == LAST_ID) ? '0 : r_gntId + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge resetH) begin
    if (resetH) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_gntValid <= 1'b0;
      r_gntId    <= '0;
      r_busIdle  <= 1'b1;
      r_rrPtr    <= '0;
      r_turnCnt  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      r_holdCnt  <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_state    <= w_nextState;
      r_gnt      <= w_gnt;
      r_gntValid <= |w_gnt;
      r_gntId    <= w_gntId;
      r_busIdle  <= (w_nextState != GRANT);
      r_rrPtr    <= w_rrPtr;
      r_turnCnt  <= w_turnCnt;
`ifdef MEM_ARB_TIMEOUT_EN
      r_holdCnt  <= w_holdCnt;
      r_timeout  <= w_timeout;
`endif
    end
  end

  assign gnt      = r_gnt;
  assign gntValid = r_gntValid;
  assign gntId    = r_gntId;
  assign busIdle  = r_busIdle;
`ifdef MEM_ARB_TIMEOUT_EN
  assign timeout  = r_timeout;
`else
  assign timeout  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_array_arbiter.sv
// ============================================================================
// Module   : tb_mem_array_arbiter
// Purpose  : Self-checking bench for mem_array_arbiter (TURN_CYCLES 1 and 3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_array_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 16;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         resetH = 1'b1;
  logic [N-1:0] req = '0;

  logic [N-1:0] gnt1, gnt3;
  logic         gntValid1, gntValid3, busIdle1, busIdle3, timeout1, timeout3;
  logic [1:0]   gntId1, gntId3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_array_arbiter #(.NUM_REQ(N), .TURN_CYCLES(1), .MAX_HOLD(MAXH)) u_dut1 (
    .clk(clk), .resetH(resetH), .req(req), .gnt(gnt1), .gntValid(gntValid1),
    .gntId(gntId1), .busIdle(busIdle1), .timeout(timeout1)
  );

  mem_array_arbiter #(.NUM_REQ(N), .TURN_CYCLES(3), .MAX_HOLD(MAXH)) u_dut3 (
    .clk(clk), .resetH(resetH), .req(req), .gnt(gnt3), .gntValid(gntValid3),
    .gntId(gntId3), .busIdle(busIdle3), .timeout(timeout3)
  );

  // Reference model: owner (-1 = none), remaining gap cycles, pointer, hold age.
  int turns[2] = '{1, 3};
  int mOwner[2], mLast[2], mPtr[2], mGap[2], mHold[2];
  bit mTo[2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic modelStep(input int m, input logic [N-1:0] r);
    mTo[m] = 1'b0;
    if (mOwner[m] >= 0) begin
      if (!r[mOwner[m]] || (TO_EN && mHold[m] == MAXH - 1)) begin
        mTo[m]    = r[mOwner[m]];
        mPtr[m]   = (mOwner[m] + 1) % N;
        mOwner[m] = -1;
        mGap[m]   = turns[m];
      end else begin
        mHold[m]++;
      end
    end else if (mGap[m] > 1) begin
      mGap[m]--;
    end else begin
      mGap[m] = 0;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (mPtr[m] + k) % N;
        if (r[i]) begin
          mOwner[m] = i;
          mLast[m]  = i;
          mHold[m]  = 0;
          break;
        end
      end
    end
  endtask

  always @(posedge clk or posedge resetH) begin
    if (resetH) begin
      for (int m = 0; m < 2; m++) begin
        mOwner[m] = -1; mLast[m] = 0; mPtr[m] = 0; mGap[m] = 0; mHold[m] = 0; mTo[m] = 1'b0;
      end
    end else begin
      for (int m = 0; m < 2; m++) modelStep(m, req);
    end
  end

  always @(negedge clk) begin
    if (!resetH) begin
      for (int m = 0; m < 2; m++) begin
        logic [N-1:0] g, eg;
        logic [1:0]   id;
        logic         v, bi, to;
        g  = (m == 0) ? gnt1 : gnt3;
        id = (m == 0) ? gntId1 : gntId3;
        v  = (m == 0) ? gntValid1 : gntValid3;
        bi = (m == 0) ? busIdle1 : busIdle3;
        to = (m == 0) ? timeout1 : timeout3;
        eg = (mOwner[m] >= 0) ? N'(1 << mOwner[m]) : '0;
        check($sformatf("gnt[dut%0d]", m), 32'(g), 32'(eg));
        check($sformatf("gntId[dut%0d]", m), 32'(id), 32'(mLast[m]));
        check($sformatf("gntValid[dut%0d]", m), 32'(v), 32'(mOwner[m] >= 0));
        check($sformatf("busIdle[dut%0d]", m), 32'(bi), 32'(mOwner[m] < 0));
        check($sformatf("timeout[dut%0d]", m), 32'(to), 32'(mTo[m]));
        check($sformatf("onehot0[dut%0d]", m), 32'($onehot0(g)), 32'd1);
      end
    end
  end

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    resetH = 1'b1;
    nextCycle();
    resetH = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hiCnt, toCnt;
    repeat (2) @(negedge clk);
    #1;
    check("rst gnt", 32'(gnt1), 32'h0);
    check("rst gntId", 32'(gntId1), 32'h0);
    check("rst busIdle", 32'(busIdle1), 32'h1);
    check("rst gntValid", 32'(gntValid1), 32'h0);
    resetH = 1'b0;

    // Single request with one-cycle latency and single gap cycle.
    nextCycle(); req = 4'b0100;
    nextCycle(); check("single gnt", 32'(gnt1), 32'h4); check("single id", 32'(gntId1), 32'd2);
    repeat (4) nextCycle();
    req = 4'b0000;
    nextCycle(); check("single gap gnt", 32'(gnt1), 32'h0); check("single gap idle", 32'(busIdle1), 32'h1);
    repeat (4) nextCycle();

    // Reset mid-grant drops gnt asynchronously and clears the pointer.
    req = 4'b0010;
    nextCycle(); check("pre-reset gnt", 32'(gnt1), 32'h2);
    #2 resetH = 1'b1;
    #1 check("async reset gnt1", 32'(gnt1), 32'h0); check("async reset gnt3", 32'(gnt3), 32'h0);
    nextCycle(); resetH = 1'b0; req = 4'b1010;
    nextCycle(); check("post-reset gnt", 32'(gnt1), 32'h2);
    req = 4'b0000;
    repeat (5) nextCycle();

    // Wrap and skip: pointer at 3 picks 0, then pointer 1 picks 2.
    req = 4'b0100;
    nextCycle(); check("wrap setup id", 32'(gntId1), 32'd2);
    req = 4'b0000;
    repeat (5) nextCycle();
    req = 4'b0101;
    nextCycle(); check("wrap gnt", 32'(gnt1), 32'h1); check("wrap id", 32'(gntId1), 32'd0);
    req = 4'b0100;
    nextCycle(); check("skip gap", 32'(gnt1), 32'h0);
    req = 4'b0101;
    nextCycle(); check("skip gnt", 32'(gnt1), 32'h4); check("skip id", 32'(gntId1), 32'd2);
    req = 4'b0000;
    repeat (5) nextCycle();

    // Round-robin with all requesting; each owner drops for one cycle.
    doReset();
    req = 4'b1111;
    nextCycle();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr gnt %0d", k), 32'(gnt1), 32'(1 << (k % 4)));
      repeat (2) nextCycle();
      req = 4'b1111 & ~N'(1 << (k % 4));
      nextCycle(); check($sformatf("rr gap %0d", k), 32'(gnt1), 32'h0);
      req = 4'b1111;
      nextCycle();
    end
    req = 4'b0000;
    repeat (6) nextCycle();

    // Turnaround direct grant on the TURN_CYCLES=3 instance.
    doReset();
    req = 4'b0010;
    nextCycle(); check("turn3 owner", 32'(gnt3), 32'h2);
    req = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      check($sformatf("turn3 gap %0d", k), 32'(gnt3), 32'h0);
      check($sformatf("turn3 idle %0d", k), 32'(busIdle3), 32'h1);
    end
    nextCycle(); check("turn3 regrant", 32'(gnt3), 32'h8);
    req = 4'b0000;
    repeat (6) nextCycle();

    // Long single hold: bounded by MAX_HOLD only when timeout is enabled.
    hiCnt = 0; toCnt = 0;
    req = 4'b0001;
    repeat (40) begin
      nextCycle();
      if (gnt1[0]) hiCnt++;
      if (timeout1) toCnt++;
    end
    check("hold high cycles", 32'(hiCnt), TO_EN ? 32'd38 : 32'd40);
    check("hold timeouts", 32'(toCnt), TO_EN ? 32'd2 : 32'd0);
    req = 4'b0000;
    repeat (6) nextCycle();

    // Random bursts with one asynchronous reset in the middle.
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      if (c == 700) begin
        #2 resetH = 1'b1;
        nextCycle();
        resetH = 1'b0;
      end else begin
        nextCycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
